divider_seq: RTL and testbench

Multi-cycle, parametrised integer divider: the sequential successor to the 16-bit combinational divider. It computes one quotient bit per clock with a restoring shift-subtract datapath, which trades latency for a short critical path at any `WIDTH`. Operands enter and results leave through valid/ready handshakes, so the block drops into pipelined datapaths and can run back-to-back. Divide-by-zero is flagged, and signed (truncating) division is a compile-time option.

---
 rtl/divider_seq.sv | 132 +++++++++++++
 tb/tb_divider_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready in and out.
// Define DIVIDER_SIGNED_EN for two's complement truncating division (default: unsigned).
module divider_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]     r_div;
  logic [WIDTH-1:0]     r_quot;
  logic [WIDTH-1:0]     r_aRaw;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_dbz;

  logic [WIDTH-1:0]     w_aMag;
  logic [WIDTH-1:0]     w_bMag;
  logic [2*WIDTH-1:0]   w_shift;
  logic [2*WIDTH-1:0]   w_workNext;
  logic [WIDTH-1:0]     w_upper;
  logic [WIDTH-1:0]     w_remRaw;
  logic [WIDTH-1:0]     w_quotNext;
  logic [WIDTH-1:0]     w_yFinal;
  logic [WIDTH-1:0]     w_remFinal;
  logic                 w_ge;
  logic                 w_accept;
  logic                 w_last;

  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // The partial remainder never exceeds the dividend prefix, so the shifted upper half fits in WIDTH bits.
  assign w_shift    = {r_work[2*WIDTH-2:0], 1'b0};
  assign w_upper    = w_shift[2*WIDTH-1:WIDTH];
  assign w_ge       = (w_upper >= r_div);
  assign w_workNext = w_ge ? {w_upper - r_div, w_shift[WIDTH-1:0]} : w_shift;
  assign w_quotNext = {r_quot[WIDTH-2:0], w_ge};
  assign w_remRaw   = w_workNext[2*WIDTH-1:WIDTH];

`ifdef DIVIDER_SIGNED_EN
  logic r_negQ;
  logic r_negR;

  assign w_aMag     = a[WIDTH-1] ? -a : a;
  assign w_bMag     = b[WIDTH-1] ? -b : b;
  assign w_yFinal   = r_negQ ? -w_quotNext : w_quotNext;
  assign w_remFinal = r_negR ? -w_remRaw : w_remRaw;
`else
  assign w_aMag     = a;
  assign w_bMag     = b;
  assign w_yFinal   = w_quotNext;
  assign w_remFinal = w_remRaw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_div       <= '0;
      r_quot      <= '0;
      r_aRaw      <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      y           <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: ;
        CALC: begin
          r_work <= w_workNext;
          r_quot <= w_quotNext;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            y           <= r_dbz ? '1 : w_yFinal;
            remainder   <= r_dbz ? r_aRaw : w_remFinal;
            div_by_zero <= r_dbz;
            out_valid   <= 1'b1;
            busy        <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Accept overrides the DONE->IDLE handoff so back-to-back operations skip IDLE.
      if (w_accept) begin
        r_work  <= {{WIDTH{1'b0}}, w_aMag};
        r_div   <= w_bMag;
        r_quot  <= '0;
        r_cnt   <= '0;
        r_aRaw  <= a;
        r_dbz   <= (b == '0);
        busy    <= 1'b1;
        r_state <= CALC;
`ifdef DIVIDER_SIGNED_EN
        r_negQ  <= a[WIDTH-1] ^ b[WIDTH-1];
        r_negR  <= a[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq at WIDTH=16; follows DIVIDER_SIGNED_EN if defined.
module tb_divider_seq;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] rem;
    logic             dbz;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  divider_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t modelDivide(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
`ifdef DIVIDER_SIGNED_EN
    int sa;
    int sd;
`endif
    exp_t e;
    if (db == '0) begin
      e.y   = '1;
      e.rem = da;
      e.dbz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa    = int'($signed(da));
      sd    = int'($signed(db));
      e.y   = WIDTH'(sa / sd);
      e.rem = WIDTH'(sa % sd);
`else
      e.y   = da / db;
      e.rem = da % db;
`endif
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Results are checked on the negedge preceding the handoff edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("y", 64'(y), 64'(e.y));
        checkOutput("remainder", 64'(remainder), 64'(e.rem));
        checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
    int waitCnt = 0;
    bit done = 1'b0;
    a = da;
    b = db;
    in_valid = 1'b1;
    while (!done && waitCnt < 100) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(modelDivide(da, db));
        done = 1'b1;
      end else begin
        waitCnt++;
      end
    end
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles, output int busyCycles);
    cycles = 0;
    busyCycles = 0;
    while (cycles < 100) begin
      if (busy) busyCycles++;
      if (out_valid) break;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!out_valid) checkOutput("result_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int bc;
    int drain;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_y", 64'(y), 64'd0);
    checkOutput("rst_remainder", 64'(remainder), 64'd0);
    checkOutput("rst_dbz", 64'(div_by_zero), 64'd0);

    $display("[TB] basic 100/7");
    applyStimulus(16'd100, 16'd7);
    waitResult(lat, bc);
    checkOutput("basic_latency", 64'(lat), 64'(WIDTH));
    checkOutput("basic_busy_cycles", 64'(bc), 64'(WIDTH));

    $display("[TB] divide by zero, with ignored in_valid during CALC");
    applyStimulus(16'h1234, 16'h0000);
    in_valid = 1'b1;
    a = 16'h0055;
    b = 16'h0005;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("calc_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    waitResult(lat, bc);
    checkOutput("dbz_latency", 64'(lat + 3), 64'(WIDTH));

    $display("[TB] backpressure then back-to-back");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(16'd500, 16'd3);
    waitResult(lat, bc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      checkOutput("hold_y", 64'(y), 64'd166);
      checkOutput("hold_remainder", 64'(remainder), 64'd2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(16'hFFFF, 16'h0001);
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    waitResult(lat, bc);
    checkOutput("b2b_latency", 64'(lat), 64'(WIDTH));

    $display("[TB] reset mid-operation");
    applyStimulus(16'd1000, 16'd10);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_y", 64'(y), 64'd0);
    checkOutput("mid_rst_remainder", 64'(remainder), 64'd0);
    checkOutput("mid_rst_dbz", 64'(div_by_zero), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(16'd9, 16'd3);
    waitResult(lat, bc);

    $display("[TB] sign and boundary patterns");
    applyStimulus(16'hFFF9, 16'h0002);
    applyStimulus(16'h0007, 16'hFFFE);
    applyStimulus(16'h8000, 16'hFFFF);
    applyStimulus(16'hFFFF, 16'h8001);
    applyStimulus(16'h0000, 16'h0005);
    applyStimulus(16'h0005, 16'hFFFF);
    applyStimulus(16'h8000, 16'h0000);

    $display("[TB] random pairs");
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = WIDTH'($urandom_range(1, 15));
        default: rb = WIDTH'($urandom);
      endcase
      applyStimulus(ra, rb);
      waitResult(lat, bc);
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end

    drain = 0;
    while (sb.size() != 0 && drain < 60) begin
      @(posedge clk);
      #1;
      drain++;
    end
    checkOutput("scoreboard_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
